// File: rtl/and_16_pkg.sv
// Shared sizing and types for the and_16_arbiter block.
//   WIDTH  : operand/result width, fixed at 16 to match my_and_16
//   N_REQ  : number of requesters (power of two, >= 2)
//   word_t : one operand or result word
//   req_id_t : requester index / round-robin pointer
package and_16_pkg;

    localparam int WIDTH = 16;
    localparam int N_REQ = 4;
    localparam int ID_W  = $clog2(N_REQ);

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [ID_W-1:0]  req_id_t;

endpackage

// File: rtl/and_16_arbiter_if.sv
// Request/result bus of the and_16_arbiter.
//   req_valid/req_a/req_b : per-requester operand offers (requester i at [i*WIDTH +: WIDTH])
//   req_ready             : one-hot or zero acceptance
//   out_valid/out_data/out_id/out_ready : single registered result channel
// Modports: master = client side, slave = arbiter side.
interface and_16_arbiter_if
    import and_16_pkg::*;
();

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   out_valid;
    word_t                  out_data;
    req_id_t                out_id;
    logic                   out_ready;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/my_and_16.sv
// Shared 16-bit bitwise AND gate array.
//   a, b : operands
//   y    : a & b
module my_and_16
    import and_16_pkg::*;
(
    input  word_t a,
    input  word_t b,
    output word_t y
);

    assign y = a & b;

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set req_valid bit in the order
// ptr, ptr+1, ... wrapping modulo N_REQ.
//   req_valid   : request vector
//   ptr         : search start position
//   grant_valid : some request was found
//   grant_id    : index of the winner (equals ptr when none found)
module rr_picker
    import and_16_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid,
    input  req_id_t          ptr,
    output logic             grant_valid,
    output req_id_t          grant_id
);

    req_id_t idx;

    // NOTE: every combinational output gets a default before the search so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ptr;
        idx         = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            // N_REQ is a power of two, so the index wraps by plain overflow.
            idx = ptr + req_id_t'(k);
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/and_16_arbiter.sv
// Round-robin arbiter sharing one my_and_16 among N_REQ requesters.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : and_16_arbiter_if.slave (requests in, registered result out)
// A grant is taken whenever the output slot is free (empty or being drained
// this cycle), so one result per cycle is sustained with out_ready high.
module and_16_arbiter
    import and_16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    and_16_arbiter_if.slave   bus
);

    logic             out_valid_q, out_valid_d;
    word_t            out_data_q,  out_data_d;
    req_id_t          out_id_q,    out_id_d;
    req_id_t          ptr_q,       ptr_d;

    logic             grant_valid;
    req_id_t          grant_id;
    logic             slot_free;
    logic             transfer;
    logic [N_REQ-1:0] req_ready;
    word_t            op_a, op_b, and_y;

    rr_picker u_picker (
        .req_valid   (bus.req_valid),
        .ptr         (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Operand mux selects only on grant_id, so req_ready never sees the data.
    assign op_a = bus.req_a[grant_id*WIDTH +: WIDTH];
    assign op_b = bus.req_b[grant_id*WIDTH +: WIDTH];

    my_and_16 u_and (
        .a (op_a),
        .b (op_b),
        .y (and_y)
    );

    assign slot_free = !out_valid_q || bus.out_ready;
    assign transfer  = grant_valid && slot_free && !reset;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = and_y;
            out_id_d    = grant_id;
            ptr_d       = grant_id + req_id_t'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_and_16_arbiter.sv
// Self-checking bench for and_16_arbiter: a vector table for steady traffic
// plus hand-written reset sequences.
module tb_and_16_arbiter;

    import and_16_pkg::*;

    typedef struct {
        string       name;
        logic [3:0]  valid;
        logic [63:0] a;
        logic [63:0] b;
        logic        out_rdy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [15:0] exp_data;
        logic [1:0]  exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    and_16_arbiter_if bus ();

    and_16_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] valid,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic out_rdy, input logic [3:0] exp_ready,
                                input logic exp_ov, input logic [15:0] exp_data,
                                input logic [1:0] exp_id);
        vec_t v;
        v.name = name; v.valid = valid; v.a = a; v.b = b; v.out_rdy = out_rdy;
        v.exp_ready = exp_ready; v.exp_ov = exp_ov; v.exp_data = exp_data; v.exp_id = exp_id;
        return v;
    endfunction

    // Called at a negedge: drive, check ready, clock once, check outputs.
    task automatic apply(input vec_t v);
        bus.req_valid = v.valid;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.out_ready = v.out_rdy;
        #1;
        check({v.name, " req_ready"}, 64'(bus.req_ready), 64'(v.exp_ready));
        @(posedge clk);
        @(negedge clk);
        check({v.name, " out_valid"}, 64'(bus.out_valid), 64'(v.exp_ov));
        check({v.name, " out_data"},  64'(bus.out_data),  64'(v.exp_data));
        check({v.name, " out_id"},    64'(bus.out_id),    64'(v.exp_id));
    endtask

    initial begin
        logic [3:0] rot_ready [6];
        logic [1:0] rot_id    [6];
        rot_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rot_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        vecs.push_back(mk("single_r2", 4'b0100, {16'h0, 16'hE000, 32'h0}, {16'h0, 16'hA000, 32'h0},
                          1'b1, 4'b0100, 1'b1, 16'hA000, 2'd2));
        vecs.push_back(mk("ptr3_wins", 4'b1001, {16'h1234, 32'h0, 16'hFFFF}, {16'h00FF, 32'h0, 16'hFFFF},
                          1'b1, 4'b1000, 1'b1, 16'h0034, 2'd3));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk($sformatf("rotate%0d", i), 4'b1111, {4{16'h000C}}, {4{16'h0004}},
                              1'b1, rot_ready[i], 1'b1, 16'h0004, rot_id[i]));
        end
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk($sformatf("stall%0d", i), 4'b1111, {4{16'hFFFF}}, {4{16'h1234}},
                              1'b0, 4'b0000, 1'b1, 16'h0004, 2'd1));
        end
        vecs.push_back(mk("stall_release", 4'b1111, {4{16'hFFFF}}, {4{16'h1234}},
                          1'b1, 4'b0100, 1'b1, 16'h1234, 2'd2));
        vecs.push_back(mk("wrap_r3", 4'b1000, {16'hF0F0, 48'h0}, {16'h0FF0, 48'h0},
                          1'b1, 4'b1000, 1'b1, 16'h00F0, 2'd3));
        vecs.push_back(mk("idle0", 4'b0000, 64'h0, 64'h0, 1'b1, 4'b0000, 1'b0, 16'h00F0, 2'd3));
        vecs.push_back(mk("idle1", 4'b0000, 64'h0, 64'h0, 1'b1, 4'b0000, 1'b0, 16'h00F0, 2'd3));
        vecs.push_back(mk("r0_after_wrap", 4'b0011, {32'h0, 16'hFFFF, 16'h0}, {32'h0, 16'hFFFF, 16'h0},
                          1'b1, 4'b0001, 1'b1, 16'h0000, 2'd0));
        vecs.push_back(mk("hold_pre_rst", 4'b0010, {32'h0, 16'hFFFF, 16'h0}, {32'h0, 16'h00FF, 16'h0},
                          1'b0, 4'b0000, 1'b1, 16'h0000, 2'd0));

        // Reset held two cycles with every requester valid.
        reset         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = {4{16'hFFFF}};
        bus.req_b     = {4{16'hFFFF}};
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst req_ready", 64'(bus.req_ready), 64'h0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst out_valid", 64'(bus.out_valid), 64'h0);
            check("rst out_data",  64'(bus.out_data),  64'h0);
            check("rst out_id",    64'(bus.out_id),    64'h0);
            check("rst req_ready hold", 64'(bus.req_ready), 64'h0);
        end
        reset = 1'b0;
        #1;
        check("post_rst req_ready", 64'(bus.req_ready), 64'b0001);

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-operation reset: result held under backpressure is dropped, ptr
        // (currently 1) returns to 0.
        reset = 1'b1;
        #1;
        check("midrst req_ready", 64'(bus.req_ready), 64'h0);
        @(posedge clk);
        @(negedge clk);
        check("midrst out_valid", 64'(bus.out_valid), 64'h0);
        check("midrst out_data",  64'(bus.out_data),  64'h0);
        reset         = 1'b0;
        bus.req_valid = 4'b1001;
        bus.req_a     = {16'h00AA, 32'h0, 16'h0F0F};
        bus.req_b     = {16'hFFFF, 32'h0, 16'hFFFF};
        bus.out_ready = 1'b1;
        #1;
        check("midrst_after req_ready", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        @(negedge clk);
        check("midrst_after out_valid", 64'(bus.out_valid), 64'h1);
        check("midrst_after out_id",    64'(bus.out_id),    64'h0);
        check("midrst_after out_data",  64'(bus.out_data),  64'h0F0F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
